// File: rtl/count_job_if.sv
// Request/grant bundle between client FSMs (master) and the shared count engine
// scheduler (slave).
interface count_job_if #(
    parameter int NUM_REQ = 4,
    parameter int CNT_W   = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
);
    logic [NUM_REQ-1:0]       req;
    logic [NUM_REQ*CNT_W-1:0] len;
    logic [NUM_REQ-1:0]       grant;
    logic [ID_W-1:0]          grant_id;
    logic [CNT_W-1:0]         counter;
    logic                     busy;
    logic [NUM_REQ-1:0]       done;
    logic                     abort;

    modport master (
        output req, len,
        input  grant, grant_id, counter, busy, done, abort
    );

    modport slave (
        input  req, len,
        output grant, grant_id, counter, busy, done, abort
    );
endinterface

// File: rtl/count_job_scheduler.sv
// Round-robin scheduler sharing one up-counter between NUM_REQ requesters:
// grant, count 0..len, pulse done (or abort if the owner drops req mid-count).
module count_job_scheduler #(
    parameter int  NUM_REQ = 4,
    parameter int  CNT_W   = 4,
    localparam int ID_W    = $clog2(NUM_REQ)
) (
    input logic       clk,
    input logic       rst,
    count_job_if.slave bus
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_COUNT = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [NUM_REQ-1:0] grant_q, grant_d;
    logic [ID_W-1:0]    grant_id_q, grant_id_d;
    logic [ID_W-1:0]    last_q, last_d;
    logic [CNT_W-1:0]   len_q, len_d;
    logic [CNT_W-1:0]   counter_q, counter_d;
    logic [NUM_REQ-1:0] done_q, done_d;
    logic               abort_q, abort_d;
    logic               busy_q, busy_d;

    logic [CNT_W-1:0]   len_arr_s [NUM_REQ];
    logic               win_found_s;
    logic [ID_W-1:0]    win_id_s;
    logic               abandon_s;
    logic               at_term_s;

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_len_unpack
        assign len_arr_s[g] = bus.len[g*CNT_W +: CNT_W];
    end

    assign abandon_s = ~bus.req[grant_id_q];
    assign at_term_s = (counter_q == len_q);

    // Round-robin search starting one past the last served requester.
    always_comb begin
        int          cand;
        logic [ID_W-1:0] cand_id;
        win_found_s = 1'b0;
        win_id_s    = '0;
        cand        = 0;
        cand_id     = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = int'(last_q) + k;
            if (cand >= NUM_REQ) begin
                cand = cand - NUM_REQ;
            end else begin
                cand = cand;
            end
            cand_id = ID_W'(cand);
            if (!win_found_s && bus.req[cand_id]) begin
                win_found_s = 1'b1;
                win_id_s    = cand_id;
            end else begin
                win_found_s = win_found_s;
            end
        end
    end

    // State and all registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            grant_q    <= '0;
            grant_id_q <= '0;
            last_q     <= ID_W'(NUM_REQ - 1);
            len_q      <= '0;
            counter_q  <= '0;
            done_q     <= '0;
            abort_q    <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            grant_id_q <= grant_id_d;
            last_q     <= last_d;
            len_q      <= len_d;
            counter_q  <= counter_d;
            done_q     <= done_d;
            abort_q    <= abort_d;
            busy_q     <= busy_d;
        end
    end

    // Next-state decode.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (win_found_s) begin
                    state_d = ST_COUNT;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_COUNT: begin
                if (abandon_s) begin
                    state_d = ST_IDLE;
                end else if (at_term_s) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_COUNT;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Next values of the registered outputs; the pointer only moves on done or abandon.
    always_comb begin
        grant_d    = grant_q;
        grant_id_d = grant_id_q;
        last_d     = last_q;
        len_d      = len_q;
        counter_d  = counter_q;
        done_d     = '0;
        abort_d    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                counter_d = '0;
                if (win_found_s) begin
                    grant_d    = {{(NUM_REQ-1){1'b0}}, 1'b1} << win_id_s;
                    grant_id_d = win_id_s;
                    len_d      = len_arr_s[win_id_s];
                end else begin
                    grant_d    = '0;
                    grant_id_d = '0;
                end
            end
            ST_COUNT: begin
                if (abandon_s) begin
                    grant_d    = '0;
                    grant_id_d = '0;
                    counter_d  = '0;
                    abort_d    = 1'b1;
                    last_d     = grant_id_q;
                end else if (at_term_s) begin
                    counter_d = '0;
                    done_d    = grant_q;
                end else begin
                    counter_d = counter_q + {{(CNT_W-1){1'b0}}, 1'b1};
                end
            end
            ST_DONE: begin
                grant_d    = '0;
                grant_id_d = '0;
                counter_d  = '0;
                last_d     = grant_id_q;
            end
            default: begin
                grant_d    = '0;
                grant_id_d = '0;
                counter_d  = '0;
            end
        endcase
        busy_d = (state_d == ST_COUNT) || (state_d == ST_DONE);
    end

    assign bus.grant    = grant_q;
    assign bus.grant_id = grant_id_q;
    assign bus.counter  = counter_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.abort    = abort_q;

endmodule

// File: tb/tb_count_job_scheduler.sv
// Self-checking bench: directed scenarios plus randomized traffic, each compared
// against a job-level reference model of the scheduler.
module tb_count_job_scheduler;

    localparam int N   = 4;
    localparam int C   = 4;
    localparam int IDW = $clog2(N);
    localparam int VW  = 2*N + IDW + C + 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    count_job_if #(.NUM_REQ(N), .CNT_W(C)) bus ();
    count_job_scheduler #(.NUM_REQ(N), .CNT_W(C)) dut (.clk(clk), .rst(rst), .bus(bus));

    int errors = 0;
    int checks = 0;

    // Reference model: phase 0 idle, 1 counting, 2 done.
    int m_phase = 0;
    int m_owner = 0;
    int m_cnt   = 0;
    int m_len   = 0;
    int m_last  = N - 1;
    bit m_abort = 1'b0;

    logic [VW-1:0] obs;
    assign obs = {bus.grant, bus.grant_id, bus.counter, bus.busy, bus.done, bus.abort};

    function automatic int len_of(int i);
        logic [N*C-1:0] v;
        v = bus.len >> (i * C);
        return int'(v[C-1:0]);
    endfunction

    task automatic model_update();
        bit found;
        int c;
        if (rst) begin
            m_phase = 0; m_owner = 0; m_cnt = 0; m_len = 0; m_last = N - 1; m_abort = 1'b0;
        end else begin
            m_abort = 1'b0;
            case (m_phase)
                0: begin
                    found = 1'b0;
                    for (int k = 1; k <= N; k++) begin
                        c = (m_last + k) % N;
                        if (!found && bus.req[c[IDW-1:0]]) begin
                            found = 1'b1; m_phase = 1; m_owner = c; m_cnt = 0; m_len = len_of(c);
                        end
                    end
                end
                1: begin
                    if (!bus.req[m_owner[IDW-1:0]]) begin
                        m_phase = 0; m_abort = 1'b1; m_last = m_owner;
                    end else if (m_cnt == m_len) begin
                        m_phase = 2;
                    end else begin
                        m_cnt = m_cnt + 1;
                    end
                end
                default: begin
                    m_phase = 0; m_last = m_owner;
                end
            endcase
        end
    endtask

    function automatic logic [VW-1:0] exp_vec();
        logic [N-1:0]   g;
        logic [IDW-1:0] id;
        logic [C-1:0]   cn;
        g  = (m_phase != 0) ? (N'(1) << m_owner) : '0;
        id = (m_phase != 0) ? IDW'(m_owner) : '0;
        cn = (m_phase == 1) ? C'(m_cnt) : '0;
        return {g, id, cn, (m_phase != 0), ((m_phase == 2) ? g : N'(0)), m_abort};
    endfunction

    task automatic step();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic set_len(int i, int v);
        bus.len[i*C +: C] = C'(v);
    endtask

    task automatic do_reset();
        rst = 1'b1; bus.req = '0; bus.len = '0;
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; bus.req = '0; bus.len = '0;
        step(); step();
        checks++;
        if (obs !== '0) begin
            errors++; $display("FAIL reset_outputs got %h expected 0", obs);
        end
        checks++;
        if (obs !== exp_vec()) begin
            errors++; $display("FAIL reset_model got %h expected %h", obs, exp_vec());
        end
        rst = 1'b0;
    endtask

    task automatic test_single();
        do_reset();
        set_len(0, 3);
        bus.req = 4'b0001;
        step();
        checks++;
        if (bus.grant !== 4'b0001 || bus.counter !== 4'd0) begin
            errors++; $display("FAIL single_grant got %b/%0d expected 0001/0", bus.grant, bus.counter);
        end
        for (int k = 1; k <= 3; k++) begin
            step();
            checks++;
            if (bus.counter !== C'(k) || obs !== exp_vec()) begin
                errors++; $display("FAIL single_count got %0d expected %0d", bus.counter, k);
            end
        end
        step();
        checks++;
        if (bus.done !== 4'b0001 || bus.grant !== 4'b0001 || bus.counter !== 4'd0) begin
            errors++; $display("FAIL single_done got done=%b grant=%b expected 0001/0001", bus.done, bus.grant);
        end
        bus.req = 4'b0000;
        step();
        checks++;
        if (obs !== '0 || obs !== exp_vec()) begin
            errors++; $display("FAIL single_idle got %h expected 0", obs);
        end
    endtask

    task automatic test_rotation();
        int exp_id;
        int ndone;
        do_reset();
        bus.len = '0;
        bus.req = 4'b1111;
        exp_id = 0; ndone = 0;
        for (int s = 0; s < 15; s++) begin
            step();
            checks++;
            if (obs !== exp_vec()) begin
                errors++; $display("FAIL rotation_model got %h expected %h", obs, exp_vec());
            end
            if (bus.done !== 4'b0000) begin
                checks++;
                if (bus.done !== (N'(1) << exp_id)) begin
                    errors++; $display("FAIL rotation_order got %b expected id %0d", bus.done, exp_id);
                end
                exp_id = (exp_id + 1) % N;
                ndone++;
            end
        end
        checks++;
        if (ndone != 5) begin
            errors++; $display("FAIL rotation_count got %0d expected 5", ndone);
        end
        bus.req = '0;
    endtask

    task automatic test_max_len();
        int ncount;
        int maxc;
        bit fin;
        do_reset();
        set_len(2, 15);
        bus.req = 4'b0100;
        ncount = 0; maxc = 0; fin = 1'b0;
        for (int s = 0; s < 40 && !fin; s++) begin
            step();
            checks++;
            if (obs !== exp_vec()) begin
                errors++; $display("FAIL maxlen_model got %h expected %h", obs, exp_vec());
            end
            if (bus.done !== 4'b0000) begin
                fin = 1'b1;
                checks++;
                if (bus.done !== 4'b0100) begin
                    errors++; $display("FAIL maxlen_done got %b expected 0100", bus.done);
                end
            end else if (bus.busy) begin
                checks++;
                if (bus.counter !== C'(ncount)) begin
                    errors++; $display("FAIL maxlen_seq got %0d expected %0d", bus.counter, ncount);
                end
                if (int'(bus.counter) > maxc) maxc = int'(bus.counter);
                ncount++;
            end
        end
        checks++;
        if (!fin || ncount != 16 || maxc != 15) begin
            errors++; $display("FAIL maxlen_cycles got fin=%0d count=%0d max=%0d expected 1/16/15", fin, ncount, maxc);
        end
        bus.req = '0;
    endtask

    task automatic test_abort();
        bit hit;
        bit saw_done;
        do_reset();
        set_len(1, 9);
        bus.req = 4'b0010;
        hit = 1'b0; saw_done = 1'b0;
        for (int s = 0; s < 20 && !hit; s++) begin
            step();
            if (bus.done !== 4'b0000) saw_done = 1'b1;
            if (bus.counter === 4'd4) hit = 1'b1;
        end
        checks++;
        if (!hit) begin
            errors++; $display("FAIL abort_reach got counter=%0d expected 4", bus.counter);
        end
        bus.req = 4'b0101;
        step();
        checks++;
        if (bus.abort !== 1'b1 || bus.grant !== 4'b0000 || bus.counter !== 4'd0 || bus.done !== 4'b0000) begin
            errors++; $display("FAIL abort_pulse got abort=%b grant=%b cnt=%0d expected 1/0000/0", bus.abort, bus.grant, bus.counter);
        end
        step();
        checks++;
        if (bus.grant !== 4'b0100 || bus.abort !== 1'b0 || obs !== exp_vec()) begin
            errors++; $display("FAIL abort_next got grant=%b expected 0100", bus.grant);
        end
        checks++;
        if (saw_done) begin
            errors++; $display("FAIL abort_nodone got done seen expected none");
        end
        bus.req = '0;
    endtask

    task automatic test_reset_mid();
        bit hit;
        do_reset();
        set_len(0, 9);
        bus.req = 4'b0001;
        hit = 1'b0;
        for (int s = 0; s < 20 && !hit; s++) begin
            step();
            if (bus.counter === 4'd5) hit = 1'b1;
        end
        rst = 1'b1;
        step();
        checks++;
        if (!hit || obs !== '0) begin
            errors++; $display("FAIL midreset_clear got %h hit=%0d expected 0", obs, hit);
        end
        rst = 1'b0;
        bus.req = 4'b1001;
        step();
        checks++;
        if (bus.grant !== 4'b0001 || bus.grant_id !== 2'd0) begin
            errors++; $display("FAIL midreset_grant got %b expected 0001", bus.grant);
        end
        bus.req = '0;
    endtask

    task automatic test_len_change();
        int ncount;
        bit fin;
        do_reset();
        set_len(0, 2);
        bus.req = 4'b0001;
        step();
        set_len(0, 7);
        ncount = 1; fin = 1'b0;
        for (int s = 0; s < 20 && !fin; s++) begin
            step();
            if (bus.done !== 4'b0000) fin = 1'b1;
            else if (bus.busy) ncount++;
        end
        checks++;
        if (!fin || ncount != 3 || bus.done !== 4'b0001) begin
            errors++; $display("FAIL lenchange got count=%0d done=%b expected 3/0001", ncount, bus.done);
        end
        bus.req = '0;
    endtask

    task automatic test_random();
        do_reset();
        for (int s = 0; s < 600; s++) begin
            bus.len = (N*C)'($urandom);
            for (int i = 0; i < N; i++) begin
                if ($urandom_range(0, 7) == 0) bus.req[i] = ~bus.req[i];
                if (bus.done[i] && $urandom_range(0, 3) != 0) bus.req[i] = 1'b0;
            end
            rst = ($urandom_range(0, 99) == 0);
            step();
            checks++;
            if (obs !== exp_vec()) begin
                errors++; $display("FAIL random_model cycle %0d got %h expected %h", s, obs, exp_vec());
            end
            checks++;
            if (!$onehot0(bus.grant) || (bus.abort && bus.done != 4'b0000)) begin
                errors++; $display("FAIL random_invariant got grant=%b done=%b abort=%b", bus.grant, bus.done, bus.abort);
            end
        end
        rst = 1'b0;
        bus.req = '0;
    endtask

    initial begin
        bus.req = '0;
        bus.len = '0;
        test_reset();
        test_single();
        test_rotation();
        test_max_len();
        test_abort();
        test_reset_mid();
        test_len_change();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/count_job_scheduler.md
Name: count_job_scheduler

Overview:
- Shares one up-counter engine between NUM_REQ requesters, so each requester sees one "go, count, done" job at a time.
- Each requester raises req with its own terminal count.
- The scheduler grants the engine round-robin, runs the count from 0 to the latched terminal, then pulses that requester's done.
- Sits between client FSMs and the shared counting datapath.

Parameters:
- NUM_REQ, 4, number of requesters (2..16).
- CNT_W, 4, counter and terminal-count width in bits.
- ID_W, $clog2(NUM_REQ), width of grant_id (derived; do not override).

Ports:
- clk  input  1  clock; all logic on posedge.
- rst  input  1  synchronous, active-high reset.
- req  input  NUM_REQ  per-requester job request; level, held until done or abandon.
- len  input  NUM_REQ*CNT_W  packed terminal counts; requester i uses len[i*CNT_W +: CNT_W].
- grant  output  NUM_REQ  one-hot owner of the engine; all zero when idle.
- grant_id  output  ID_W  index of the current owner; 0 when idle.
- counter  output  CNT_W  engine count value.
- busy  output  1  high in COUNT and DONE.
- done  output  NUM_REQ  one-cycle completion pulse, one-hot.
- abort  output  1  one-cycle pulse when a job is abandoned.

Behaviour:
- Clock and reset: one clock, clk; reset rst is synchronous and active-high. The reset branch has priority over every other assignment.
- Reset values:
  - state=IDLE; grant=0; grant_id=0; counter=0; busy=0; done=0; abort=0.
  - Round-robin pointer last=NUM_REQ-1, so requester 0 has first priority after reset.
- All outputs are registered.
- States: IDLE, COUNT, DONE.
- IDLE:
  - If req!=0, select the first set bit searching last+1, last+2, ... modulo NUM_REQ.
  - Latch winner index into grant_id/grant and its len into len_q; set counter=0; next state COUNT.
  - If req==0, stay in IDLE.
  - len is sampled only at this edge; later changes to len are ignored for that job.
- COUNT:
  - If req[grant_id]==0 (abandon): next state IDLE; counter=0; grant=0; grant_id=0; abort pulses 1 cycle; last=grant_id; no done.
  - Else if counter==len_q: next state DONE; counter=0; grant held.
  - Else counter=counter+1.
  - counter takes the values 0,1,...,len_q, so COUNT lasts len_q+1 cycles. len_q=0 gives one COUNT cycle.
  - counter never wraps, since the terminal is at most 2^CNT_W-1. len_q=all-ones counts to max, then goes to DONE with no overflow.
- DONE (exactly 1 cycle):
  - done[grant_id]=1 and grant still asserted in this cycle.
  - Next state IDLE: grant=0, grant_id=0, last=grant_id.
  - The requester must drop req on seeing done. If req is still high in IDLE, it is treated as a new request.
- Minimum job-to-job gap: one IDLE cycle between DONE and the next COUNT.
- Latency from a req edge in IDLE to grant visible: 1 clock.
- Fairness:
  - Pointer updates only on DONE or abandon.
  - With all req high, grants rotate 0,1,2,3,0,...
  - A requester waits at most NUM_REQ-1 jobs.
- Simultaneous requests in IDLE: only the round-robin winner is granted; the others wait, with no loss.
- req changes of non-owners during COUNT/DONE have no effect.
- Reset mid-job: the job is lost with no done or abort; reset values apply on the next edge.
- Invariants:
  - grant is one-hot or zero.
  - done and abort are never both high.
  - grant=0 implies busy=0 and counter=0.

Test Plan:
- Reset then req=4'b0001, len0=3 -> grant=0001 one clock later; counter 0,1,2,3 over 4 cycles; done=0001 for 1 cycle; grant=0 next; total 6 cycles from req to IDLE.
- req=4'b1111, all len=0 after reset -> grants in order 0,1,2,3,0; each job is COUNT 1 cycle + DONE 1 cycle + IDLE 1 cycle; done pulses one-hot in the same order.
- len2=4'hF, only req[2] -> counter reaches 15, no wrap to 0 inside COUNT; done[2] after 16 COUNT cycles.
- Requester 1 granted with len=9; drop req[1] when counter=4 -> abort pulses; counter=0 and grant=0 next cycle; done never asserted; next grant search starts at 2.
- Assert rst while counter=5 in COUNT -> next edge: all outputs 0; pointer reset so req=4'b1001 grants requester 0 first.
- Change len0 from 2 to 7 during requester 0's COUNT -> count still stops at 2.
